tb_scenario_sequencer: RTL and testbench
========================================

// Module: tb_scenario_sequencer
// PURPOSE
//  Testbench command sequencer that sits directly upstream of the SET injector.
//  Buffers pre-tokenized scenario commands (5 string args each) and executes them in order:
//    SET -> one-cycle dispatch of args plus select to the injector; WTR -> cycle-count stall;
//    END -> end-of-test.
//  Gives scenario-driven stimulus deterministic, cycle-exact timing.
// PARAMETERS
//  FIFO_DEPTH  8   command buffer depth in entries (power of 2, >=2)
//  NB_ARGS     5   string tokens per command (args[0] = keyword)
//  ERR_W       8   width of unknown-keyword error counter
// PORTS
//  clk           in   1             clock, all logic on posedge
//  rst_n         in   1             reset, synchronous, active-low
//  i_cmd_valid   in   1             command push request
//  i_cmd_args    in   string[NB_ARGS]  tokenized command; sampled when valid && ready
//  o_cmd_ready   out  1             buffer can accept a command
//  o_set_sel     out  1             injector select, one-cycle pulse per SET
//  o_args_valid  out  1             injector args strobe, coincident with o_set_sel
//  o_args        out  string[NB_ARGS]  args of last dispatched command; held until next pop
//  o_wait_busy   out  1             high during WTR stall cycles
//  o_end_test    out  1             high from END execution until reset
//  o_err_cnt     out  ERR_W         count of unknown keywords, saturating
//  o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current buffer occupancy
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, FIFO emptied, level 0.
//   Outputs: set_sel, args_valid, wait_busy and end_test = 0; err_cnt = 0; all o_args = "".
//   Reset mid-WTR or mid-DISPATCH aborts the command; buffered commands are discarded.
//  Push: accepted on a posedge where i_cmd_valid && o_cmd_ready.
//   o_cmd_ready = !full && state!=DONE (combinational).
//   Push and pop in the same cycle are allowed when not full; level is unchanged.
//   When full, a push is refused even if a pop happens that cycle.
//  FSM (registered outputs):
//   IDLE:
//    - FIFO empty -> stay.
//    - Otherwise pop the head into o_args and decode args[0] (case-sensitive):
//      "SET" -> o_set_sel=1, o_args_valid=1, go DISPATCH.
//      "WTR" -> n = args[1].atoi().
//         n<=0 -> stay IDLE; no busy cycle.
//         n>0  -> cnt=n, o_wait_busy=1, go WAIT.
//      "END" -> o_end_test=1, go DONE.
//      other -> o_err_cnt++ (saturating at 2**ERR_W-1), stay IDLE; command dropped.
//   DISPATCH: clear o_set_sel and o_args_valid, go IDLE.
//   WAIT: cnt--. When cnt==1: clear o_wait_busy and go IDLE.
//    WTR n therefore gives exactly n cycles of o_wait_busy high.
//   DONE: terminal. o_end_test held 1, no pops, o_cmd_ready=0.
//  Latency:
//   - Command pushed at edge k into an empty FIFO: popped at edge k+1; its outputs are
//     visible after edge k+1.
//   - Consecutive SETs dispatch at most once every 2 cycles.
//  o_args_valid and o_set_sel are always equal; the consumer needs both high in the same cycle.
//  WTR count is 32-bit signed (atoi); non-numeric text evaluates to 0, i.e. no stall.
// STRUCTURE
//  Package tb_seq_pkg:
//   - typedef enum {S_IDLE,S_DISPATCH,S_WAIT,S_DONE} seq_state_t
//   - string constants KW_SET="SET", KW_WTR="WTR", KW_END="END"
//   - localparam NB_ARGS_DEF=5
//  Sub-module tb_cmd_fifo: synchronous FIFO of string[NB_ARGS] entries.
//   - Interfaces: push/pop/full/empty/level.
//   - Reads are show-ahead: the head entry is visible while the FIFO is not empty.
// TESTING
//  1. Push {"SET","reg_a","0000FFFF","",""}: after pop, sel=valid=1 for exactly 1 cycle,
//     o_args[1]="reg_a"; then IDLE.
//  2. Push WTR "5" then SET: busy high exactly 5 cycles; SET dispatches on the cycle after
//     busy falls.
//  3. Fill 8 commands with the sequencer stalled in WTR 20: ready=0 at level 8.
//     The 9th push is refused. All 8 commands execute in order afterwards.
//  4. Push "FOO", then "SET": err_cnt=1, the SET still dispatches. WTR "0" produces no busy
//     cycle.
//  5. Push END then SET: end_test=1 and held, ready=0. The SET is never dispatched;
//     level stays 1.
//  6. Assert rst_n=0 during WTR 10 at cycle 4: busy=0 and level=0 next edge, state IDLE,
//     o_args="".

Source files
------------

// File: rtl/tb_seq_pkg.sv
// tb_seq_pkg: shared state encoding, keyword constants and defaults for the scenario sequencer.
package tb_seq_pkg;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_DONE} seq_state_t;

    localparam string KW_SET = "SET";
    localparam string KW_WTR = "WTR";
    localparam string KW_END = "END";

    localparam int NB_ARGS_DEF = 5;

endpackage

// File: rtl/tb_cmd_fifo.sv
// tb_cmd_fifo: show-ahead synchronous FIFO of tokenized commands (NB_ARGS strings per entry).
module tb_cmd_fifo #(
    parameter int DEPTH   = 8,
    parameter int NB_ARGS = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  string                  i_data [NB_ARGS],
    input  logic                   i_pop,
    output string                  o_head [NB_ARGS],
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    string         mem_q [DEPTH][NB_ARGS];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop;

    always_comb begin
        o_full  = level_q == LW'(DEPTH);
        o_empty = level_q == '0;
        push    = i_push && !o_full;
        pop     = i_pop && !o_empty;
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        level_d = level_q + LW'(push) - LW'(pop);
        o_level = level_q;
        o_head  = mem_q[rd_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            if (push)
                for (int a = 0; a < NB_ARGS; a++) mem_q[wr_q][a] <= i_data[a];
        end
    end

endmodule

// File: rtl/tb_scenario_sequencer.sv
// tb_scenario_sequencer: buffers tokenized scenario commands and executes SET/WTR/END
// in order with cycle-exact timing towards the SET injector.
module tb_scenario_sequencer
    import tb_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int NB_ARGS    = NB_ARGS_DEF,
    parameter int ERR_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_cmd_valid,
    input  string                       i_cmd_args [NB_ARGS],
    output logic                        o_cmd_ready,
    output logic                        o_set_sel,
    output logic                        o_args_valid,
    output string                       o_args [NB_ARGS],
    output logic                        o_wait_busy,
    output logic                        o_end_test,
    output logic [ERR_W-1:0]            o_err_cnt,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

    seq_state_t         state_q, state_d;
    logic               sel_q, sel_d, busy_q, busy_d, end_q, end_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic signed [31:0] cnt_q, cnt_d;
    string              args_q [NB_ARGS];
    string              args_d [NB_ARGS];
    string              head [NB_ARGS];
    logic               full, empty, push, pop;
    int                 wtr_n;

    tb_cmd_fifo #(.DEPTH(FIFO_DEPTH), .NB_ARGS(NB_ARGS)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (push),
        .i_data  (i_cmd_args),
        .i_pop   (pop),
        .o_head  (head),
        .o_full  (full),
        .o_empty (empty),
        .o_level (o_fifo_level)
    );

    assign o_cmd_ready  = !full && state_q != S_DONE;
    assign push         = i_cmd_valid && o_cmd_ready;
    assign o_set_sel    = sel_q;
    assign o_args_valid = sel_q;
    assign o_wait_busy  = busy_q;
    assign o_end_test   = end_q;
    assign o_err_cnt    = err_q;

    always_comb o_args = args_q;

    always_comb begin
        state_d = state_q;
        sel_d   = 1'b0;
        busy_d  = busy_q;
        end_d   = end_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        args_d  = args_q;
        pop     = 1'b0;
        wtr_n   = 0;
        case (state_q)
            S_IDLE:
                if (!empty) begin
                    pop    = 1'b1;
                    args_d = head;
                    if (head[0] == KW_SET) begin
                        sel_d   = 1'b1;
                        state_d = S_DISPATCH;
                    end else if (head[0] == KW_WTR) begin
                        wtr_n = head[1].atoi();
                        if (wtr_n > 0) begin
                            cnt_d   = wtr_n;
                            busy_d  = 1'b1;
                            state_d = S_WAIT;
                        end
                    end else if (head[0] == KW_END) begin
                        end_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + 1'b1;
                    end
                end
            S_DISPATCH: state_d = S_IDLE;
            S_WAIT: begin
                cnt_d = cnt_q - 1;
                if (cnt_q == 1) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
            for (int a = 0; a < NB_ARGS; a++) args_q[a] <= "";
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            end_q   <= end_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            args_q  <= args_d;
        end
    end

endmodule

// File: tb/tb_tb_scenario_sequencer.sv
// tb_tb_scenario_sequencer: directed checks of the scenario sequencer with hand-computed
// expectations for dispatch, stall, buffering, error and end-of-test behaviour.
module tb_tb_scenario_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    string      args [5];
    logic       ready, sel, args_valid, busy, end_test;
    string      o_args [5];
    logic [7:0] err_cnt;
    logic [3:0] level;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    tb_scenario_sequencer #(.FIFO_DEPTH(8), .NB_ARGS(5), .ERR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cmd_valid  (valid),
        .i_cmd_args   (args),
        .o_cmd_ready  (ready),
        .o_set_sel    (sel),
        .o_args_valid (args_valid),
        .o_args       (o_args),
        .o_wait_busy  (busy),
        .o_end_test   (end_test),
        .o_err_cnt    (err_cnt),
        .o_fifo_level (level)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for exactly one edge; acceptance depends on ready at that edge.
    task automatic push(input string a0, input string a1, input string a2);
        args[0] = a0;
        args[1] = a1;
        args[2] = a2;
        args[3] = "";
        args[4] = "";
        valid   = 1'b1;
        step();
        valid   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int    cnt;
        int    pulses;
        int    idx;
        string exp_s;

        do_reset();
        chk("rst_sel", sel, 0);
        chk("rst_valid", args_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_end", end_test, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", ready, 1);
        chk("rst_args0_empty", int'(o_args[0] == ""), 1);

        // Single SET: one-cycle strobe with args held afterwards
        push("SET", "reg_a", "0000FFFF");
        chk("t1_level_pushed", level, 1);
        chk("t1_sel_before", sel, 0);
        step();
        chk("t1_sel", sel, 1);
        chk("t1_valid", args_valid, 1);
        chk("t1_arg1", int'(o_args[1] == "reg_a"), 1);
        chk("t1_arg2", int'(o_args[2] == "0000FFFF"), 1);
        chk("t1_level_popped", level, 0);
        step();
        chk("t1_sel_clear", sel, 0);
        chk("t1_valid_clear", args_valid, 0);
        chk("t1_arg1_held", int'(o_args[1] == "reg_a"), 1);

        // WTR 5 then SET
        push("WTR", "5", "");
        push("SET", "after_wtr", "");
        chk("t2_busy_start", busy, 1);
        chk("t2_level", level, 1);
        cnt = 1;
        for (int i = 0; i < 20 && busy; i++) begin
            step();
            if (busy) cnt++;
        end
        chk("t2_busy_cycles", cnt, 5);
        chk("t2_sel_at_fall", sel, 0);
        step();
        chk("t2_sel_after_fall", sel, 1);
        chk("t2_arg1", int'(o_args[1] == "after_wtr"), 1);
        step();

        // Fill the buffer behind WTR 20, then drain in order
        push("WTR", "20", "");
        for (int i = 0; i < 8; i++) push("SET", $sformatf("c%0d", i), "");
        chk("t3_level_full", level, 8);
        chk("t3_ready_full", ready, 0);
        chk("t3_busy", busy, 1);
        push("SET", "c8", "");
        chk("t3_level_refused", level, 8);
        idx = 0;
        for (int i = 0; i < 200 && idx < 9; i++) begin
            step();
            if (sel) begin
                exp_s = $sformatf("c%0d", idx);
                chk($sformatf("t3_order_%0d", idx), int'(o_args[1] == exp_s), 1);
                idx++;
            end
            if (idx == 8 && level == 0) begin
                for (int j = 0; j < 4; j++) begin
                    step();
                    if (sel) idx++;
                end
                break;
            end
        end
        chk("t3_dispatch_count", idx, 8);
        chk("t3_level_drained", level, 0);

        // Unknown keyword, case sensitivity, WTR 0
        push("FOO", "x", "");
        push("SET", "s4", "");
        chk("t4_err", err_cnt, 1);
        chk("t4_level", level, 1);
        step();
        chk("t4_sel", sel, 1);
        chk("t4_arg1", int'(o_args[1] == "s4"), 1);
        step();
        push("set", "lower", "");
        step();
        chk("t4_err_case", err_cnt, 2);
        chk("t4_no_sel_lower", sel, 0);
        push("WTR", "0", "");
        step();
        chk("t4_wtr0_busy", busy, 0);
        step();
        chk("t4_wtr0_busy_next", busy, 0);
        push("WTR", "abc", "");
        step();
        chk("t4_wtr_text_busy", busy, 0);
        chk("t4_err_unchanged", err_cnt, 2);

        // END is terminal: no pops, ready low
        push("END", "", "");
        push("SET", "never", "");
        chk("t5_end", end_test, 1);
        chk("t5_args0", int'(o_args[0] == "END"), 1);
        chk("t5_ready", ready, 0);
        chk("t5_level", level, 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sel) pulses++;
        end
        chk("t5_no_dispatch", pulses, 0);
        chk("t5_end_held", end_test, 1);
        chk("t5_level_held", level, 1);

        // Reset in the middle of a stall
        do_reset();
        chk("t6_end_cleared", end_test, 0);
        chk("t6_err_cleared", err_cnt, 0);
        push("WTR", "10", "");
        push("SET", "dropped", "");
        chk("t6_busy", busy, 1);
        step();
        step();
        step();
        chk("t6_busy_c4", busy, 1);
        chk("t6_level_c4", level, 1);
        rst_n = 1'b0;
        step();
        chk("t6_busy_rst", busy, 0);
        chk("t6_level_rst", level, 0);
        chk("t6_args0_rst", int'(o_args[0] == ""), 1);
        chk("t6_args1_rst", int'(o_args[1] == ""), 1);
        rst_n = 1'b1;
        step();
        chk("t6_no_dispatch", sel, 0);
        push("SET", "post", "");
        step();
        chk("t6_idle_sel", sel, 1);
        chk("t6_idle_arg1", int'(o_args[1] == "post"), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
